j1_uart_io: RTL and testbench

Memory-mapped UART peripheral that sits directly downstream of the j1 core on its I/O bus. It decodes the core's `io_rd`/`io_wr`/`mem_addr`/`dout` strobes and returns read data combinationally on `io_din` in the same cycle. The block provides an 8N1 transmitter, an 8N1 receiver feeding an RX FIFO, and a status register, so Forth words `emit`, `key` and `key?` map onto single I/O instructions.

---
 rtl/j1_io_pkg.sv | 36 +++
 rtl/j1_rx_fifo.sv | 63 ++++++
 rtl/j1_uart_io.sv | 264 ++++++++++++++++++++++++++
 tb/tb_j1_uart_io.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/j1_io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : j1_io_pkg
// Brief    : Shared constants and state types for the j1 UART I/O peripheral.
//            Holds the default register addresses, the status bit positions
//            and the TX/RX state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package j1_io_pkg;

  // Default register addresses on the j1 I/O bus
  localparam logic [15:0] c_ADDR_DATA = 16'h1000;
  localparam logic [15:0] c_ADDR_STAT = 16'h2000;

  // Status register bit positions
  localparam int c_STAT_RXV = 0;
  localparam int c_STAT_TXR = 1;
  localparam int c_STAT_OVR = 2;
  localparam int c_STAT_FRM = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/j1_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : j1_rx_fifo
// Brief    : Byte FIFO for received UART characters. Head is combinational;
//            a push while full is accepted only when a pop happens in the
//            same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module j1_rx_fifo #(
  parameter int unsigned RX_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] din_i,
  output logic [7:0] head_o,
  output logic       empty_o,
  output logic       full_o
);

  localparam int AW = $clog2(RX_DEPTH);

  // Pointers carry one extra MSB so full and empty are distinguishable
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [RX_DEPTH];
  logic        w_do_pop;
  logic        w_do_push;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);
  assign head_o    = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance for accepted push and pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule
`default_nettype wire

// File: rtl/j1_uart_io.sv
`default_nettype none
// ============================================================================
// Module   : j1_uart_io
// Brief    : Memory-mapped 8N1 UART for the j1 core I/O bus. Data register
//            writes start a TX frame, reads pop the RX FIFO; the status
//            register reports rx_valid, tx_ready and two sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
module j1_uart_io
  import j1_io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned RX_DEPTH     = 8,
  parameter logic [15:0] ADDR_DATA    = c_ADDR_DATA,
  parameter logic [15:0] ADDR_STAT    = c_ADDR_STAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] mem_addr,
  input  logic [15:0] dout,
  output logic [15:0] io_din,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  // Last cycle of a bit period
  localparam logic [TW-1:0] c_BIT_LAST = TW'(CLKS_PER_BIT - 1);
  // Start-bit sample point: low is first seen one edge after the synchronizer
  // output falls, so the half-bit count is shortened by that edge as well
  localparam logic [TW-1:0] c_HALF_CMP = TW'(CLKS_PER_BIT / 2 - 2);

  // Bus decode
  logic w_sel_data, w_sel_stat, w_tx_accept, w_pop, w_stat_rd;
  assign w_sel_data  = (mem_addr == ADDR_DATA);
  assign w_sel_stat  = (mem_addr == ADDR_STAT);
  assign w_pop       = io_rd && w_sel_data;
  assign w_stat_rd   = io_rd && w_sel_stat;

  // Upper write-data byte carries nothing for this peripheral
  logic w_unused_dout;
  assign w_unused_dout = ^dout[15:8];

  // TX state
  tx_state_e     tx_state_q, tx_state_d;
  logic [TW-1:0] tx_timer_q, tx_timer_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_line_q, tx_line_d;

  assign w_tx_accept = io_wr && w_sel_data && (tx_state_q == TX_IDLE);
  assign uart_tx     = tx_line_q;

  // RX state
  rx_state_e     rx_state_q, rx_state_d;
  logic [TW-1:0] rx_timer_q, rx_timer_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_meta_q, rx_sync_q;
  logic          w_rx_push, w_frm_set, w_ovr_set;

  // FIFO and flags
  logic [7:0]  w_head;
  logic        w_empty, w_full;
  logic        ovr_q, ovr_d, frm_q, frm_d;
  logic [15:0] w_status;

  j1_rx_fifo #(
    .RX_DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (w_rx_push),
    .pop_i   (w_pop),
    .din_i   (rx_shift_q),
    .head_o  (w_head),
    .empty_o (w_empty),
    .full_o  (w_full)
  );

  // TX: next state, bit timing and serial line value
  always_comb begin
    tx_state_d = tx_state_q;
    tx_timer_d = tx_timer_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (w_tx_accept) begin
          tx_state_d = TX_START;
          tx_timer_d = '0;
          tx_shift_d = dout[7:0];
          tx_line_d  = 1'b0;
        end
      end
      TX_START: begin
        if (tx_timer_q == c_BIT_LAST) begin
          tx_state_d = TX_DATA;
          tx_timer_d = '0;
          tx_bit_d   = '0;
          tx_line_d  = tx_shift_q[0];
        end else begin
          tx_timer_d = tx_timer_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_timer_q == c_BIT_LAST) begin
          tx_timer_d = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_bit_d  = tx_bit_q + 1'b1;
            tx_line_d = tx_shift_q[1];
          end
        end else begin
          tx_timer_d = tx_timer_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_timer_q == c_BIT_LAST) begin
          tx_state_d = TX_IDLE;
          tx_timer_d = '0;
        end else begin
          tx_timer_d = tx_timer_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX registers; the line idles high
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_timer_q <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_timer_q <= tx_timer_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
    end
  end

  // RX: two-flop synchronizer on the asynchronous serial input
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // RX: start detection, mid-bit sampling and stop-bit verdict
  always_comb begin
    rx_state_d = rx_state_q;
    rx_timer_d = rx_timer_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    w_rx_push  = 1'b0;
    w_frm_set  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          rx_timer_d = '0;
        end
      end
      RX_START: begin
        if (rx_timer_q == c_HALF_CMP) begin
          rx_timer_d = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_timer_d = rx_timer_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_timer_q == c_BIT_LAST) begin
          rx_timer_d = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_timer_d = rx_timer_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_timer_q == c_BIT_LAST) begin
          rx_timer_d = '0;
          rx_state_d = RX_IDLE;
          w_rx_push  = rx_sync_q;
          w_frm_set  = !rx_sync_q;
        end else begin
          rx_timer_d = rx_timer_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_timer_q <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_timer_q <= rx_timer_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // A push into a full FIFO is lost unless a pop frees a slot that cycle
  assign w_ovr_set = w_rx_push && w_full && !w_pop;

  // Sticky flags: a status read clears them, a set in the same cycle wins
  always_comb begin
    ovr_d = w_ovr_set || (ovr_q && !w_stat_rd);
    frm_d = w_frm_set || (frm_q && !w_stat_rd);
  end

  // Sticky flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_q <= 1'b0;
      frm_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
      frm_q <= frm_d;
    end
  end

  // Status word assembly
  always_comb begin
    w_status             = '0;
    w_status[c_STAT_RXV] = !w_empty;
    w_status[c_STAT_TXR] = (tx_state_q == TX_IDLE);
    w_status[c_STAT_OVR] = ovr_q;
    w_status[c_STAT_FRM] = frm_q;
  end

  // Read mux back to the core, same cycle as the strobe
  always_comb begin
    io_din = '0;
    if (w_sel_data)      io_din = {8'h00, (w_empty ? 8'h00 : w_head)};
    else if (w_sel_stat) io_din = w_status;
  end

endmodule
`default_nettype wire

// File: tb/tb_j1_uart_io.sv
`default_nettype none
// ============================================================================
// Module   : tb_j1_uart_io
// Brief    : Self-checking bench for j1_uart_io with a queue-based model of
//            the RX FIFO and sticky flags, and frame-level TX/RX stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_j1_uart_io;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [15:0] A_DATA = 16'h1000;
  localparam logic [15:0] A_STAT = 16'h2000;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_rd, io_wr;
  logic [15:0] mem_addr, dout;
  wire  [15:0] io_din;
  logic        uart_rx;
  wire         uart_tx;

  j1_uart_io #(
    .CLKS_PER_BIT (CPB),
    .RX_DEPTH     (DEPTH),
    .ADDR_DATA    (A_DATA),
    .ADDR_STAT    (A_STAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .io_rd    (io_rd),
    .io_wr    (io_wr),
    .mem_addr (mem_addr),
    .dout     (dout),
    .io_din   (io_din),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: received bytes in arrival order plus sticky flags
  logic [7:0] m_q[$];
  logic       m_ovr, m_frm;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_stat();
    return {12'h000, m_frm, m_ovr, 1'b1, (m_q.size() != 0)};
  endfunction

  function automatic logic [15:0] m_pop();
    if (m_q.size() == 0) return 16'h0000;
    return {8'h00, m_q.pop_front()};
  endfunction

  task automatic m_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok)                 m_frm = 1'b1;
    else if (m_q.size() >= DEPTH) m_ovr = 1'b1;
    else                          m_q.push_back(b);
  endtask

  // All bus tasks are entered on a falling edge and leave on the next one
  task automatic peek(input logic [15:0] a, output logic [15:0] v);
    mem_addr = a;
    #1 v = io_din;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [15:0] v);
    io_rd = 1'b1;
    mem_addr = a;
    #1 v = io_din;
    @(negedge clk);
    io_rd = 1'b0;
  endtask

  task automatic peek_stat_chk(input string tag);
    logic [15:0] v;
    peek(A_STAT, v);
    check(tag, v, m_stat());
  endtask

  task automatic rd_stat_chk(input string tag);
    logic [15:0] v;
    bus_rd(A_STAT, v);
    check(tag, v, m_stat());
    m_ovr = 1'b0;
    m_frm = 1'b0;
  endtask

  task automatic rd_data_chk(input string tag);
    logic [15:0] v;
    bus_rd(A_DATA, v);
    check(tag, v, m_pop());
  endtask

  // Drive one 8N1 frame; a bad stop bit is low for most of its period.
  // Optionally issues a data read on the last cycle of the stop bit.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input bit pop_at_stop, output logic [15:0] popv);
    logic bitv;
    popv = 16'h0000;
    for (int j = 0; j < 10; j++) begin
      bitv = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
      for (int c = 0; c < CPB; c++) begin
        if (j == 9 && !stop_ok) uart_rx = (c == CPB - 1);
        else if (c == 0)        uart_rx = bitv;
        if (pop_at_stop && j == 9 && c == CPB - 1) begin
          io_rd = 1'b1;
          mem_addr = A_DATA;
          #1 popv = io_din;
        end
        @(negedge clk);
      end
    end
    io_rd = 1'b0;
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic glitch();
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Write a byte and follow the whole frame bit by bit
  task automatic tx_frame_chk(input logic [15:0] d, input bit drop_probe);
    logic [7:0]  b;
    logic [15:0] v;
    logic        expbit;
    int          k;
    b = d[7:0];
    io_wr = 1'b1;
    mem_addr = A_DATA;
    dout = d;
    @(negedge clk);
    io_wr = 1'b0;
    for (int i = 0; i < 10 * CPB; i++) begin
      if (i == 9) io_wr = 1'b0;
      k = i / CPB;
      expbit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      peek(A_STAT, v);
      check("tx_busy", v & 16'h0002, 16'h0000);
      check("tx_bit", {15'b0, uart_tx}, {15'b0, expbit});
      if (drop_probe && i == 8) begin
        io_wr = 1'b1;
        mem_addr = A_DATA;
        dout = 16'h00AA;
      end
      @(negedge clk);
    end
    peek(A_STAT, v);
    check("tx_ready_back", v & 16'h0002, 16'h0002);
    check("tx_idle_line", {15'b0, uart_tx}, 16'h0001);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    logic [7:0]  b;
    int          act;

    reset = 1'b1; io_rd = 1'b0; io_wr = 1'b0;
    mem_addr = 16'h0000; dout = 16'h0000; uart_rx = 1'b1;
    m_ovr = 1'b0; m_frm = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_tx_line", {15'b0, uart_tx}, 16'h0001);
    peek(A_STAT, v);  check("rst_stat", v, 16'h0002);
    peek(A_DATA, v);  check("rst_data", v, 16'h0000);
    peek(16'h3000, v); check("rst_other", v, 16'h0000);
    reset = 1'b0;
    @(negedge clk);

    // Load state that a reset must discard, then reset mid TX frame
    send_frame(8'h3C, 1'b1, 1'b0, v); m_frame(8'h3C, 1'b1);
    send_frame(8'h11, 1'b0, 1'b0, v); m_frame(8'h11, 1'b0);
    peek_stat_chk("pre_rst_stat");
    io_wr = 1'b1; mem_addr = A_DATA; dout = 16'h0000;
    @(negedge clk);
    io_wr = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_frame_line", {15'b0, uart_tx}, 16'h0000);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_q.delete(); m_ovr = 1'b0; m_frm = 1'b0;
    check("rst_mid_tx_line", {15'b0, uart_tx}, 16'h0001);
    peek(A_STAT, v); check("rst_mid_stat", v, 16'h0002);
    peek(A_DATA, v); check("rst_mid_data", v, 16'h0000);
    @(negedge clk);

    // TX: fixed pattern with a dropped write, then random bytes back to back
    tx_frame_chk(16'h1255, 1'b1);
    for (int t = 0; t < 3; t++) tx_frame_chk(16'($urandom), 1'b0);

    // RX single frame
    send_frame(8'hA3, 1'b1, 1'b0, v); m_frame(8'hA3, 1'b1);
    peek_stat_chk("rx_a3_stat");
    check("rx_a3_stat_lit", m_stat(), 16'h0003);
    rd_data_chk("rx_a3_data");
    rd_data_chk("rx_empty_data");

    // Overrun after five frames into a four-entry FIFO
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 1'b1, 1'b0, v);
      m_frame(8'(k), 1'b1);
    end
    peek_stat_chk("ovr_stat");
    for (int k = 0; k < 5; k++) rd_data_chk("ovr_drain");
    rd_stat_chk("ovr_clear_rd");
    peek_stat_chk("ovr_cleared");

    // Framing error, then a glitch that must leave nothing behind
    send_frame(8'h5A, 1'b0, 1'b0, v); m_frame(8'h5A, 1'b0);
    peek_stat_chk("frm_stat");
    rd_stat_chk("frm_clear_rd");
    glitch();
    peek_stat_chk("glitch_stat");

    // Full FIFO with a pop coinciding with the stop-bit push
    for (int k = 0; k < DEPTH; k++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 1'b0, v);
      m_frame(b, 1'b1);
    end
    peek_stat_chk("full_stat");
    b = 8'($urandom);
    send_frame(b, 1'b1, 1'b1, v);
    check("pop_at_push", v, m_pop());
    m_frame(b, 1'b1);
    peek_stat_chk("pop_push_stat");
    for (int k = 0; k <= DEPTH; k++) rd_data_chk("pop_push_drain");

    // Random mix of frames, reads, bad frames and glitches
    for (int t = 0; t < 30; t++) begin
      act = int'($urandom_range(0, 5));
      case (act)
        0, 1: begin
          b = 8'($urandom);
          send_frame(b, 1'b1, 1'b0, v);
          m_frame(b, 1'b1);
        end
        2: begin
          b = 8'($urandom);
          send_frame(b, 1'b0, 1'b0, v);
          m_frame(b, 1'b0);
        end
        3: rd_data_chk("rnd_data");
        4: rd_stat_chk("rnd_stat_rd");
        default: glitch();
      endcase
      peek_stat_chk("rnd_stat");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
